// File: rtl/pwm_duty_generator.sv
// ---------------------------------------------------------------------------
// pwm_duty_generator
//
// Generates a PWM waveform whose high time per period equals the applied
// duty value. A period is MAX clock cycles long. Duty updates are
// double-buffered: a loaded value waits in a shadow register and is applied
// at the next period boundary, so a period never changes shape mid-way.
// Dropping enable lets the current period finish (DRAIN) before idling.
//
// Ports:
//   clk          - system clock, rising edge
//   reset        - asynchronous active-low reset
//   enable       - run request, level-sensitive
//   duty_in      - new duty value (high cycles per period)
//   duty_load    - capture strobe for duty_in, sampled every edge
//   pwm_out      - PWM waveform (registered)
//   period_start - pulse in the count==0 cycle of every running period
//   duty_active  - duty value applied to the current period
//   pending      - a loaded duty is waiting for the next boundary
//   running      - high in RUN and DRAIN
// ---------------------------------------------------------------------------
module pwm_duty_generator #(
    parameter int WIDTH = 8,
    parameter int MAX   = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             duty_load,
    output logic             pwm_out,
    output logic             period_start,
    output logic [WIDTH-1:0] duty_active,
    output logic             pending,
    output logic             running
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX - 1);
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_active;
    logic             r_pending;
    logic             r_pwm;
    logic             r_pstart;

    logic             w_at_last;
    logic             w_boundary;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_active_nxt;
    logic [WIDTH-1:0] w_shadow_nxt;
    logic             w_pending_nxt;
    logic [WIDTH-1:0] w_duty_eff;
    logic             w_run_nxt;

    assign w_at_last = (r_count == LAST);

    // A boundary is the edge that starts a new running period: leaving IDLE
    // with enable, or wrapping while enable is still requested. Wrapping
    // into IDLE is deliberately not a boundary, so no shadow transfer there.
    assign w_boundary = enable && ((r_state == S_IDLE) || w_at_last);

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        if (r_state == S_IDLE) begin
            w_count_nxt = '0;
            if (enable) begin
                w_state_nxt = S_RUN;
            end
        end else if (enable) begin
            // RUN keeps running; DRAIN resumes RUN without restarting count
            w_state_nxt = S_RUN;
            w_count_nxt = w_at_last ? '0 : r_count + 1'b1;
        end else if (w_at_last) begin
            w_state_nxt = S_IDLE;
            w_count_nxt = '0;
        end else begin
            w_state_nxt = S_DRAIN;
            w_count_nxt = r_count + 1'b1;
        end
    end

    always_comb begin
        w_active_nxt  = r_active;
        w_shadow_nxt  = r_shadow;
        w_pending_nxt = r_pending;
        if (w_boundary && duty_load) begin
            // bypass: the value loaded on the boundary applies immediately
            w_active_nxt  = duty_in;
            w_shadow_nxt  = duty_in;
            w_pending_nxt = 1'b0;
        end else if (w_boundary) begin
            if (r_pending) begin
                w_active_nxt  = r_shadow;
                w_pending_nxt = 1'b0;
            end
        end else if (duty_load) begin
            w_shadow_nxt  = duty_in;
            w_pending_nxt = 1'b1;
        end
    end

    // Duty at or above MAX means no low cycle in the period
    assign w_duty_eff = (w_active_nxt >= MAXV) ? MAXV : w_active_nxt;
    assign w_run_nxt  = (w_state_nxt != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_shadow  <= '0;
            r_active  <= '0;
            r_pending <= 1'b0;
            r_pwm     <= 1'b0;
            r_pstart  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_shadow  <= w_shadow_nxt;
            r_active  <= w_active_nxt;
            r_pending <= w_pending_nxt;
            // outputs registered from next-cycle values so they line up
            // with the count they describe
            r_pwm     <= w_run_nxt && (w_count_nxt < w_duty_eff);
            r_pstart  <= w_run_nxt && (w_count_nxt == '0);
        end
    end

    assign pwm_out      = r_pwm;
    assign period_start = r_pstart;
    assign duty_active  = r_active;
    assign pending      = r_pending;
    assign running      = (r_state != S_IDLE);

endmodule

// File: doc/pwm_duty_generator.md
Name: pwm_duty_generator

Overview:
- Generates a PWM waveform from an 8-bit duty value. It is the transmit-side counterpart of the duty-cycle measurement block.
- Each period is MAX clock cycles long. Output is high for exactly duty_active cycles per period, so a measurement block with an equal window reads back the programmed value.
- Duty updates are double-buffered and applied only at period boundaries, giving glitch-free changes.
- Stopping is graceful: the current period always completes before the output goes idle.

Parameters:
- WIDTH, 8, width of duty and period counter.
- MAX, 255, period length in clk cycles; legal range 2..(2^WIDTH)-1.

Ports:
- clk  input  1  system clock, all flops on rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  run request; level-sensitive.
- duty_in  input  WIDTH  new duty value (high cycles per period).
- duty_load  input  1  strobe; duty_in is captured on every clock edge where this is 1.
- pwm_out  output  1  PWM waveform, driven from a flop.
- period_start  output  1  one-cycle pulse in the first cycle (count==0) of every running period.
- duty_active  output  WIDTH  duty value applied to the current period.
- pending  output  1  a loaded duty is waiting for the next boundary.
- running  output  1  high in RUN and DRAIN states.

Behaviour:
- Reset (async, reset==0): state=IDLE, count=0, duty_shadow=0, duty_active=0, pending=0, pwm_out=0, period_start=0, running=0. Takes effect immediately, including mid-period. Operation restarts only after reset release plus enable.
- State machine IDLE / RUN / DRAIN:
  - IDLE -> RUN on an edge with enable=1; that edge sets count=0 (boundary edge).
  - RUN: count increments each cycle, 0..MAX-1. The edge at count==MAX-1 wraps to 0 (boundary edge).
  - RUN -> DRAIN when enable=0 is sampled with count != MAX-1. If count==MAX-1 with enable=0, go directly to IDLE.
  - DRAIN: keeps counting. DRAIN -> RUN if enable=1 is sampled; counting continues with no gap or restart. DRAIN -> IDLE on the edge at count==MAX-1 with enable=0.
  - Entering IDLE: count=0, pwm_out=0, period_start=0.
- Waveform: in the running cycle where count==k, pwm_out = (k < duty_eff). Here duty_eff = duty_active clamped to MAX.
  - duty 0: constant low.
  - duty >= MAX: constant high, with no low cycle.
  - In IDLE, pwm_out=0.
- period_start=1 exactly in cycles where running && count==0.
- Duty buffering:
  - duty_load on a non-boundary edge: duty_shadow<=duty_in, pending<=1. Multiple loads within a period: last wins.
  - Boundary edge without duty_load: if pending, duty_active<=duty_shadow and pending<=0; else duty_active unchanged.
  - Boundary edge with duty_load (bypass): duty_active<=duty_in, duty_shadow<=duty_in, pending<=0. The new value applies to the period just starting.
  - Loads in IDLE set pending; the value is applied at the IDLE->RUN edge.
  - duty_active is stable for the entire period. It changes only on boundary edges.
- Entering IDLE (including stop from RUN at count==MAX-1) is not a boundary edge and does not transfer shadow. Pending persists.
- Width: count is WIDTH bits and never reaches MAX. The comparison is unsigned.

Test Plan:
- reset, enable=1, load 64 in IDLE -> first period: pwm_out high count 0..63, low 64..254. period_start pulses every 255 cycles. duty_active=64, pending=0 from first RUN cycle.
- Load 0, then 255 -> a period fully low, then a period fully high (255 consecutive highs across the whole period). period_start keeps pulsing. With MAX=200 and load 250 -> clamps to constant high.
- active 50, load 100 at count 30, then load 200 at count 40 -> current period 50 highs, pending=1 until the boundary. Next period 200 highs. Load 77 at count 254 -> bypass: next period 77 highs, pending stays 0.
- Drop enable at count 100 -> running stays 1, full period completes (duty highs intact), then IDLE, pwm_out=0, running=0. Re-raise enable at count 150 in DRAIN -> no gap; next period_start occurs 255 cycles after the previous one.
- Assert reset asynchronously mid-high at count 20 -> pwm_out and all outputs 0 before the next clk edge. After release with enable=1, count restarts at 0 with duty_active=0 (output low).
- Loopback: drive duty 128 into the duty-cycle measurement block with a 255-cycle window -> measured value 128 ±0 once aligned to period_start.
